// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - N-stage pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; op, shamt, A are sampled on transfer
//   op                    00 SLL, 01 SRL, 10 SRA, 11 ROL
//   shamt [N-1:0]         shift amount 0..W-1
//   A     [W-1:0]         operand
//   out_valid / out_ready output handshake
//   Y     [W-1:0]         result (last stage register)

module pipelined_shifter #(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [N-1:0]        shamt,
    input  logic [(2**N)-1:0]   A,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(2**N)-1:0]   Y
);

    localparam int W = 2**N;

    logic [N-1:0] valid;
    logic [N-1:0] rdy;

    // A stage may load when it is empty or when some stage downstream of it
    // is empty (bubble collapse), or when the output is being consumed.
    always_comb begin
        logic hole;
        hole = 1'b0;
        rdy  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            hole   = hole | ~valid[k];
            rdy[k] = hole | out_ready;
        end
    end

    for (genvar k = 0; k < N; k++) begin : stg
        localparam int S = 2**k;

        logic [W-1:0]   d_in;
        logic [1:0]     op_in;
        logic [N-k-1:0] rem_in;     // shamt bits k..N-1; bit 0 selects this stage
        logic           v_in;
        logic [W-1:0]   d_sh;
        logic [W-1:0]   data_q;
        logic           v_q;

        if (k == 0) begin : src
            assign d_in   = A;
            assign op_in  = op;
            assign rem_in = shamt;
            assign v_in   = in_valid;
        end else begin : src
            assign d_in   = stg[k-1].data_q;
            assign op_in  = stg[k-1].fwd.op_q;
            assign rem_in = stg[k-1].fwd.rem_q;
            assign v_in   = stg[k-1].v_q;
        end

        // S <= W/2 for every stage, so all slices below are non-empty.
        always_comb begin
            case (op_in)
                2'b00:   d_sh = {d_in[W-1-S:0], {S{1'b0}}};
                2'b01:   d_sh = {{S{1'b0}}, d_in[W-1:S]};
                2'b10:   d_sh = {{S{d_in[W-1]}}, d_in[W-1:S]};
                default: d_sh = {d_in[W-1-S:0], d_in[W-1:W-S]};
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                data_q <= '0;
            end else if (rdy[k]) begin
                v_q    <= v_in;
                data_q <= rem_in[0] ? d_sh : d_in;
            end
        end

        assign valid[k] = v_q;

        // op and the unconsumed shamt bits only travel to later stages.
        if (k < N - 1) begin : fwd
            logic [1:0]     op_q;
            logic [N-k-2:0] rem_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_q  <= '0;
                    rem_q <= '0;
                end else if (rdy[k]) begin
                    op_q  <= op_in;
                    rem_q <= rem_in[N-k-1:1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid[N-1];
    assign Y         = stg[N-1].data_q;

endmodule
